// File: rtl/tracking_history.sv
// Per-channel tracking front end: squares one E/P/L I/Q dump per code period and holds k/k-1 history.
// Latency: dump accepted at edge e0 -> i2q2_valid high for the single cycle following edge e0+6.
// Backpressure: none; a dump arriving while busy is dropped, flagged by dump_overrun and counted (saturating).
module tracking_history #(
    parameter int ACC_WIDTH      = 16,
    parameter int I2Q2_WIDTH     = 32,
    parameter int IQ_WIDTH       = 16,
    parameter int W_DF_WIDTH     = 20,
    parameter int W_DF_DOT_WIDTH = 20
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             init,
    input  logic signed [W_DF_WIDTH-1:0]     init_w_df,
    input  logic                             dump_valid,
    input  logic signed [ACC_WIDTH-1:0]      i_early,
    input  logic signed [ACC_WIDTH-1:0]      q_early,
    input  logic signed [ACC_WIDTH-1:0]      i_prompt,
    input  logic signed [ACC_WIDTH-1:0]      q_prompt,
    input  logic signed [ACC_WIDTH-1:0]      i_late,
    input  logic signed [ACC_WIDTH-1:0]      q_late,
    output logic                             i2q2_valid,
    output logic [I2Q2_WIDTH-1:0]            i2q2_early_k,
    output logic [I2Q2_WIDTH-1:0]            i2q2_prompt_k,
    output logic [I2Q2_WIDTH-1:0]            i2q2_late_k,
    output logic signed [ACC_WIDTH-1:0]      i_prompt_k,
    output logic signed [ACC_WIDTH-1:0]      q_prompt_k,
    output logic signed [ACC_WIDTH-1:0]      i_prompt_km1,
    output logic signed [ACC_WIDTH-1:0]      q_prompt_km1,
    output logic [IQ_WIDTH-1:0]              iq_prompt_km1,
    output logic signed [W_DF_WIDTH-1:0]     w_df_k,
    output logic signed [W_DF_DOT_WIDTH-1:0] w_df_dot_k,
    input  logic                             tracking_ready,
    input  logic [IQ_WIDTH-1:0]              iq_prompt_k_in,
    input  logic signed [W_DF_WIDTH-1:0]     w_df_kp1,
    input  logic signed [W_DF_DOT_WIDTH-1:0] w_df_dot_kp1,
    output logic                             busy,
    output logic                             dump_overrun,
    output logic [7:0]                       overrun_count
);

    // I2Q2_WIDTH is expected to be exactly 2*ACC_WIDTH: the largest sum of
    // two full-scale squares is 2^(2*ACC_WIDTH-1), which just fits unsigned.

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_SQUARE  = 2'd1,
        S_PRESENT = 2'd2,
        S_WAIT    = 2'd3
    } state_t;

    localparam logic [2:0] LAST_SQ = 3'd5;

    state_t state_q, state_d;
    logic [2:0] sq_cnt_q, sq_cnt_d;

    // Latched dump values, one register per operand
    logic signed [ACC_WIDTH-1:0] ie_q, qe_q, ip_q, qp_q, il_q, ql_q;

    // Tap accumulators (these are the i2q2 outputs)
    logic [I2Q2_WIDTH-1:0] acc_e_q, acc_p_q, acc_l_q;

    // History committed from the tracking stage
    logic signed [ACC_WIDTH-1:0]      ip_km1_q, qp_km1_q;
    logic [IQ_WIDTH-1:0]              iq_km1_q;
    logic signed [W_DF_WIDTH-1:0]     w_df_q;
    logic signed [W_DF_DOT_WIDTH-1:0] w_df_dot_q;

    // Overrun bookkeeping
    logic       ovr_pulse_q;
    logic [7:0] ovr_cnt_q;

    logic accept;
    logic commit;
    logic drop;

    // Shared multiplier operand and its square
    logic signed [ACC_WIDTH-1:0]   sq_op;
    logic signed [2*ACC_WIDTH-1:0] sq_op_ext;
    logic signed [2*ACC_WIDTH-1:0] sq_prod;
    logic [I2Q2_WIDTH-1:0]         sq_val;

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            sq_cnt_q <= 3'd0;
        end else begin
            state_q  <= state_d;
            sq_cnt_q <= sq_cnt_d;
        end
    end

    // Next-state logic; init overrides every transition and suppresses accept/commit
    always_comb begin
        state_d  = state_q;
        sq_cnt_d = sq_cnt_q;
        accept   = 1'b0;
        commit   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (dump_valid) begin
                    accept   = 1'b1;
                    sq_cnt_d = 3'd0;
                    state_d  = S_SQUARE;
                end
            end
            S_SQUARE: begin
                sq_cnt_d = sq_cnt_q + 3'd1;
                if (sq_cnt_q == LAST_SQ) begin
                    state_d = S_PRESENT;
                end
            end
            S_PRESENT: begin
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (tracking_ready) begin
                    commit  = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        if (init) begin
            state_d  = S_IDLE;
            sq_cnt_d = 3'd0;
            accept   = 1'b0;
            commit   = 1'b0;
        end
    end

    // A dump arriving in any non-idle state is lost; init swallows a same-edge dump silently
    assign drop = dump_valid && !init && (state_q != S_IDLE);

    // Operand select: I_E, Q_E, I_P, Q_P, I_L, Q_L on counts 0..5
    always_comb begin
        sq_op = '0;
        case (sq_cnt_q)
            3'd0:    sq_op = ie_q;
            3'd1:    sq_op = qe_q;
            3'd2:    sq_op = ip_q;
            3'd3:    sq_op = qp_q;
            3'd4:    sq_op = il_q;
            3'd5:    sq_op = ql_q;
            default: sq_op = '0;
        endcase
    end

    // Sign-extend before multiplying so the square is exact at full precision;
    // (-2^(W-1))^2 = 2^(2W-2) is still representable as a positive signed value.
    assign sq_op_ext = {{ACC_WIDTH{sq_op[ACC_WIDTH-1]}}, sq_op};
    assign sq_prod   = sq_op_ext * sq_op_ext;
    assign sq_val    = sq_prod;

    // Dump latch: captured on accept, cleared by init
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ie_q <= '0;
            qe_q <= '0;
            ip_q <= '0;
            qp_q <= '0;
            il_q <= '0;
            ql_q <= '0;
        end else if (init) begin
            ie_q <= '0;
            qe_q <= '0;
            ip_q <= '0;
            qp_q <= '0;
            il_q <= '0;
            ql_q <= '0;
        end else if (accept) begin
            ie_q <= i_early;
            qe_q <= q_early;
            ip_q <= i_prompt;
            qp_q <= q_prompt;
            il_q <= i_late;
            ql_q <= q_late;
        end
    end

    // Tap accumulators: cleared on accept, each square added into its tap during SQUARE
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc_e_q <= '0;
            acc_p_q <= '0;
            acc_l_q <= '0;
        end else if (init || accept) begin
            acc_e_q <= '0;
            acc_p_q <= '0;
            acc_l_q <= '0;
        end else if (state_q == S_SQUARE) begin
            case (sq_cnt_q[2:1])
                2'd0:    acc_e_q <= acc_e_q + sq_val;
                2'd1:    acc_p_q <= acc_p_q + sq_val;
                2'd2:    acc_l_q <= acc_l_q + sq_val;
                default: acc_l_q <= acc_l_q;
            endcase
        end
    end

    // History: loaded from the tracking stage on commit, seeded on init
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ip_km1_q   <= '0;
            qp_km1_q   <= '0;
            iq_km1_q   <= '0;
            w_df_q     <= '0;
            w_df_dot_q <= '0;
        end else if (init) begin
            ip_km1_q   <= '0;
            qp_km1_q   <= '0;
            iq_km1_q   <= '0;
            w_df_q     <= init_w_df;
            w_df_dot_q <= '0;
        end else if (commit) begin
            ip_km1_q   <= ip_q;
            qp_km1_q   <= qp_q;
            iq_km1_q   <= iq_prompt_k_in;
            w_df_q     <= w_df_kp1;
            w_df_dot_q <= w_df_dot_kp1;
        end
    end

    // Overrun pulse and saturating drop counter
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ovr_pulse_q <= 1'b0;
            ovr_cnt_q   <= 8'd0;
        end else if (init) begin
            ovr_pulse_q <= 1'b0;
            ovr_cnt_q   <= 8'd0;
        end else begin
            ovr_pulse_q <= drop;
            if (drop && (ovr_cnt_q != 8'hFF)) begin
                ovr_cnt_q <= ovr_cnt_q + 8'd1;
            end
        end
    end

    // Pulse outputs decode straight from state so an async reset drops them at once
    assign i2q2_valid    = (state_q == S_PRESENT);
    assign busy          = (state_q != S_IDLE);
    assign i2q2_early_k  = acc_e_q;
    assign i2q2_prompt_k = acc_p_q;
    assign i2q2_late_k   = acc_l_q;
    assign i_prompt_k    = ip_q;
    assign q_prompt_k    = qp_q;
    assign i_prompt_km1  = ip_km1_q;
    assign q_prompt_km1  = qp_km1_q;
    assign iq_prompt_km1 = iq_km1_q;
    assign w_df_k        = w_df_q;
    assign w_df_dot_k    = w_df_dot_q;
    assign dump_overrun  = ovr_pulse_q;
    assign overrun_count = ovr_cnt_q;

endmodule

// File: tb/tb_tracking_history.sv
module tb_tracking_history;

    logic clk;
    logic reset;
    logic init;
    logic signed [19:0] init_w_df;
    logic dump_valid;
    logic signed [15:0] i_early, q_early, i_prompt, q_prompt, i_late, q_late;
    logic i2q2_valid;
    logic [31:0] i2q2_early_k, i2q2_prompt_k, i2q2_late_k;
    logic signed [15:0] i_prompt_k, q_prompt_k, i_prompt_km1, q_prompt_km1;
    logic [15:0] iq_prompt_km1;
    logic signed [19:0] w_df_k, w_df_dot_k;
    logic tracking_ready;
    logic [15:0] iq_prompt_k_in;
    logic signed [19:0] w_df_kp1, w_df_dot_kp1;
    logic busy;
    logic dump_overrun;
    logic [7:0] overrun_count;

    tracking_history dut (
        .clk(clk), .reset(reset), .init(init), .init_w_df(init_w_df),
        .dump_valid(dump_valid),
        .i_early(i_early), .q_early(q_early), .i_prompt(i_prompt),
        .q_prompt(q_prompt), .i_late(i_late), .q_late(q_late),
        .i2q2_valid(i2q2_valid), .i2q2_early_k(i2q2_early_k),
        .i2q2_prompt_k(i2q2_prompt_k), .i2q2_late_k(i2q2_late_k),
        .i_prompt_k(i_prompt_k), .q_prompt_k(q_prompt_k),
        .i_prompt_km1(i_prompt_km1), .q_prompt_km1(q_prompt_km1),
        .iq_prompt_km1(iq_prompt_km1), .w_df_k(w_df_k), .w_df_dot_k(w_df_dot_k),
        .tracking_ready(tracking_ready), .iq_prompt_k_in(iq_prompt_k_in),
        .w_df_kp1(w_df_kp1), .w_df_dot_kp1(w_df_dot_kp1),
        .busy(busy), .dump_overrun(dump_overrun), .overrun_count(overrun_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int checks = 0;
    int errors = 0;

    // Reference model: the dump being worked on and the committed history
    logic signed [15:0] dv [6];
    logic signed [15:0] m_ip, m_qp, m_ipkm1, m_qpkm1;
    logic [15:0]        m_iq;
    logic signed [19:0] m_wdf, m_wdd;
    int                 m_ovr;
    longint             m_e, m_p, m_l;

    function automatic longint sq(input logic signed [15:0] v);
        return longint'(v) * longint'(v);
    endfunction

    task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        m_ip = 0; m_qp = 0; m_ipkm1 = 0; m_qpkm1 = 0; m_iq = 0;
        m_wdf = 0; m_wdd = 0; m_ovr = 0; m_e = 0; m_p = 0; m_l = 0;
    endtask

    task automatic chk_hist(input string tag);
        chk({tag, ".i_km1"}, i_prompt_km1, m_ipkm1);
        chk({tag, ".q_km1"}, q_prompt_km1, m_qpkm1);
        chk({tag, ".iq_km1"}, iq_prompt_km1, m_iq);
        chk({tag, ".w_df"}, w_df_k, m_wdf);
        chk({tag, ".w_df_dot"}, w_df_dot_k, m_wdd);
        chk({tag, ".ovr_cnt"}, overrun_count, m_ovr);
    endtask

    task automatic chk_out(input string tag);
        chk({tag, ".early"}, i2q2_early_k, m_e);
        chk({tag, ".prompt"}, i2q2_prompt_k, m_p);
        chk({tag, ".late"}, i2q2_late_k, m_l);
    endtask

    task automatic drive_dv();
        i_early = dv[0]; q_early = dv[1]; i_prompt = dv[2];
        q_prompt = dv[3]; i_late = dv[4]; q_late = dv[5];
    endtask

    task automatic random_dv();
        for (int j = 0; j < 6; j++) begin
            dv[j] = 16'($urandom());
            if ($urandom_range(7) == 0) dv[j] = 16'sh8000;
        end
    endtask

    // Full dump from accept through PRESENT into WAIT_TRACK; optionally a
    // second dump is presented on the first SQUARE edge and must be dropped.
    task automatic run_dump(input string tag, input bit inject_drop);
        drive_dv();
        dump_valid = 1'b1;
        tick();
        dump_valid = 1'b0;
        m_ip = dv[2];
        m_qp = dv[3];
        m_e  = sq(dv[0]) + sq(dv[1]);
        m_p  = sq(dv[2]) + sq(dv[3]);
        m_l  = sq(dv[4]) + sq(dv[5]);
        chk({tag, ".busy_after_accept"}, busy, 1);
        if (inject_drop) begin
            dump_valid = 1'b1;
            i_early = 16'sh1111; q_early = -16'sh2222; i_prompt = 16'sh0101;
            q_prompt = 16'sh7fff; i_late = 16'sh8000; q_late = 16'sh0042;
        end
        for (int k = 1; k <= 5; k++) begin
            tick();
            if (k == 1) begin
                dump_valid = 1'b0;
                if (inject_drop && m_ovr < 255) m_ovr++;
                chk({tag, ".ovr_pulse"}, dump_overrun, inject_drop);
                chk({tag, ".ovr_cnt"}, overrun_count, m_ovr);
            end
            chk({tag, ".valid_early"}, i2q2_valid, 0);
        end
        tick();
        chk({tag, ".valid"}, i2q2_valid, 1);
        chk_out(tag);
        chk({tag, ".i_prompt_k"}, i_prompt_k, m_ip);
        chk({tag, ".q_prompt_k"}, q_prompt_k, m_qp);
        chk_hist(tag);
        tick();
        chk({tag, ".valid_one_cycle"}, i2q2_valid, 0);
        chk({tag, ".busy_wait"}, busy, 1);
        chk_out({tag, ".hold"});
    endtask

    task automatic do_commit(input string tag, input logic [15:0] iq, input logic signed [19:0] wdf,
                             input logic signed [19:0] wdd, input bit with_dump);
        tracking_ready = 1'b1;
        iq_prompt_k_in = iq;
        w_df_kp1 = wdf;
        w_df_dot_kp1 = wdd;
        if (with_dump) begin
            random_dv();
            drive_dv();
            dump_valid = 1'b1;
        end
        tick();
        tracking_ready = 1'b0;
        dump_valid = 1'b0;
        m_ipkm1 = m_ip;
        m_qpkm1 = m_qp;
        m_iq = iq;
        m_wdf = wdf;
        m_wdd = wdd;
        if (with_dump && m_ovr < 255) m_ovr++;
        chk_hist(tag);
        chk({tag, ".busy"}, busy, 0);
        chk({tag, ".ovr_pulse"}, dump_overrun, with_dump);
    endtask

    initial begin
        reset = 1'b1; init = 1'b0; init_w_df = '0; dump_valid = 1'b0;
        i_early = '0; q_early = '0; i_prompt = '0; q_prompt = '0; i_late = '0; q_late = '0;
        tracking_ready = 1'b0; iq_prompt_k_in = '0; w_df_kp1 = '0; w_df_dot_kp1 = '0;
        model_reset();
        #2;
        // Reset state
        chk("rst.busy", busy, 0);
        chk("rst.valid", i2q2_valid, 0);
        chk("rst.ovr_pulse", dump_overrun, 0);
        chk_out("rst");
        chk_hist("rst");
        repeat (2) tick();
        reset = 1'b0;
        tick();

        // First directed dump
        dv[0] = 3; dv[1] = 4; dv[2] = -5; dv[3] = 12; dv[4] = 0; dv[5] = -7;
        run_dump("d1", 1'b0);
        chk("d1.early_const", i2q2_early_k, 25);
        chk("d1.prompt_const", i2q2_prompt_k, 169);
        chk("d1.late_const", i2q2_late_k, 49);

        do_commit("c1", 16'd13, -20'sd100, 20'sd5, 1'b0);
        chk("c1.iq_const", iq_prompt_km1, 13);
        chk("c1.i_km1_const", i_prompt_km1, -5);
        chk("c1.q_km1_const", q_prompt_km1, 12);
        chk("c1.w_df_const", w_df_k, -100);
        chk("c1.w_df_dot_const", w_df_dot_k, 5);
        tick();

        // Full-scale negative on every operand
        for (int j = 0; j < 6; j++) dv[j] = 16'sh8000;
        run_dump("max", 1'b0);
        chk("max.early_const", i2q2_early_k, 32'h80000000);
        chk("max.prompt_const", i2q2_prompt_k, 32'h80000000);
        chk("max.late_const", i2q2_late_k, 32'h80000000);
        chk("max.i_km1_const", i_prompt_km1, -5);
        do_commit("cmax", 16'($urandom()), 20'($urandom()), 20'($urandom()), 1'b0);

        // Randomized periods with idle gaps
        for (int n = 0; n < 25; n++) begin
            repeat ($urandom_range(3)) begin
                tick();
                chk("rnd.idle_valid", i2q2_valid, 0);
                chk("rnd.idle_busy", busy, 0);
            end
            random_dv();
            run_dump("rnd", 1'b0);
            repeat ($urandom_range(2)) begin
                tick();
                chk("rnd.wait_busy", busy, 1);
            end
            do_commit("rndc", 16'($urandom()), 20'($urandom()), 20'($urandom()), 1'b0);
        end

        // Overruns: one during SQUARE, then 300 while waiting for the tracking stage
        tick();
        random_dv();
        run_dump("ovr", 1'b1);
        for (int n = 0; n < 300; n++) begin
            dump_valid = 1'b1;
            i_early = 16'($urandom()); i_prompt = 16'($urandom()); q_late = 16'($urandom());
            tick();
            if (m_ovr < 255) m_ovr++;
            chk("ovr.pulse", dump_overrun, 1);
            chk("ovr.cnt", overrun_count, m_ovr);
        end
        dump_valid = 1'b0;
        chk("ovr.cnt_sat", overrun_count, 255);
        chk_out("ovr.unchanged");
        chk("ovr.i_prompt_k", i_prompt_k, m_ip);
        chk("ovr.busy", busy, 1);
        // Commit and a dump on the same edge: commit wins, dump dropped
        do_commit("ovrc", 16'($urandom()), 20'($urandom()), 20'($urandom()), 1'b1);
        tick();
        chk("ovrc.pulse_end", dump_overrun, 0);
        chk("ovrc.idle", busy, 0);

        // init during SQUARE with a same-edge dump
        random_dv();
        drive_dv();
        dump_valid = 1'b1;
        tick();
        dump_valid = 1'b0;
        tick();
        init = 1'b1;
        init_w_df = 20'sd1234;
        dump_valid = 1'b1;
        tick();
        init = 1'b0;
        dump_valid = 1'b0;
        m_ipkm1 = 0; m_qpkm1 = 0; m_iq = 0; m_wdf = 1234; m_wdd = 0; m_ovr = 0;
        m_e = 0; m_p = 0; m_l = 0;
        chk("init.busy", busy, 0);
        chk("init.ovr_pulse", dump_overrun, 0);
        chk("init.w_df_const", w_df_k, 1234);
        chk_hist("init");
        chk_out("init");
        for (int n = 0; n < 10; n++) begin
            tick();
            chk("init.no_valid", i2q2_valid, 0);
            chk("init.stay_idle", busy, 0);
        end

        // tracking_ready in IDLE must not touch history
        random_dv();
        run_dump("pre", 1'b0);
        do_commit("prec", 16'($urandom()), 20'($urandom()), 20'($urandom()), 1'b0);
        tick();
        tracking_ready = 1'b1;
        iq_prompt_k_in = ~m_iq;
        w_df_kp1 = ~m_wdf;
        w_df_dot_kp1 = ~m_wdd;
        tick();
        tracking_ready = 1'b0;
        tick();
        chk_hist("idle_tr");
        chk("idle_tr.busy", busy, 0);

        // Reset asserted mid-SQUARE
        random_dv();
        drive_dv();
        dump_valid = 1'b1;
        tick();
        dump_valid = 1'b0;
        tick();
        tick();
        #2;
        reset = 1'b1;
        #1;
        model_reset();
        chk("arst.busy", busy, 0);
        chk("arst.valid", i2q2_valid, 0);
        chk("arst.ovr_pulse", dump_overrun, 0);
        chk("arst.i_prompt_k", i_prompt_k, 0);
        chk_out("arst");
        chk_hist("arst");
        tick();
        reset = 1'b0;
        for (int n = 0; n < 10; n++) begin
            tick();
            chk("arst.no_valid", i2q2_valid, 0);
            chk("arst.idle", busy, 0);
        end

        // Normal operation resumes after reset
        random_dv();
        run_dump("post", 1'b0);
        do_commit("postc", 16'($urandom()), 20'($urandom()), 20'($urandom()), 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
